// File: rtl/uart_conv16to8_pkg.sv
// Shared UART frame definitions: widths, frame tags and converter state encoding.
package uart_conv16to8_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BYTE_W  = 8;

  // Frame tags carried in the top nibble of each word; tag 0 is the mux idle word.
  localparam logic [3:0] TAG_PL2_POSX   = 4'h1;
  localparam logic [3:0] TAG_PL2_POSY   = 4'h2;
  localparam logic [3:0] TAG_MATCH_CTRL = 4'h3;

  localparam logic [2:0] ST_SETTLE  = 3'd0;
  localparam logic [2:0] ST_SEND_HI = 3'd1;
  localparam logic [2:0] ST_WAIT_HI = 3'd2;
  localparam logic [2:0] ST_SEND_LO = 3'd3;
  localparam logic [2:0] ST_WAIT_LO = 3'd4;

  typedef enum logic [2:0] {
    StSettle = ST_SETTLE,
    StSendHi = ST_SEND_HI,
    StWaitHi = ST_WAIT_HI,
    StSendLo = ST_SEND_LO,
    StWaitLo = ST_WAIT_LO
  } conv_state_e;

  // Select the high or low byte of a frame word.
  function automatic logic [BYTE_W-1:0] frame_byte(input logic [FRAME_W-1:0] word,
                                                   input logic hi);
    return hi ? word[FRAME_W-1 -: BYTE_W] : word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_watchdog.sv
// Byte-completion watchdog: counts cycles while run is high and flags expiry after
// TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables expiry.
module uart_tx_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up while running and hold at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = ENABLED && run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_conv16to8.sv
// Splits each 16-bit frame word into two bytes (high first) for the byte-wide UART
// transmitter and tells the word mux when the pending tx_done completes a word.
module uart_conv16to8
  import uart_conv16to8_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] data_in,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               conv16to8ready,
  output logic               timeout_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  conv_state_e        state_q;
  logic [3:0]         settle_q;
  logic [FRAME_W-1:0] word_q;
  logic               wd_clear;
  logic               wd_run;
  logic               wd_expired;

  // The watchdog restarts on the single SEND cycle preceding each WAIT state.
  assign wd_clear = (state_q == StSendHi) || (state_q == StSendLo);
  assign wd_run   = (state_q == StWaitHi) || (state_q == StWaitLo);

  uart_tx_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .run    (wd_run),
    .expired(wd_expired)
  );

  // Converter FSM; every output is set on the edge entering the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StSettle;
      settle_q       <= '0;
      word_q         <= '0;
      tx_start       <= 1'b0;
      tx_data        <= '0;
      conv16to8ready <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      unique case (state_q)
        StSettle: begin
          // Mux select and data register have settled by the last count.
          if (settle_q == SETTLE_LAST) begin
            word_q   <= data_in;
            tx_data  <= frame_byte(data_in, 1'b1);
            tx_start <= 1'b1;
            settle_q <= '0;
            state_q  <= StSendHi;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        StSendHi: begin
          tx_data <= frame_byte(word_q, 1'b1);
          state_q <= StWaitHi;
        end
        StWaitHi: begin
          if (tx_done || wd_expired) begin
            if (!tx_done) begin
              timeout_err <= 1'b1;
            end
            tx_data  <= frame_byte(word_q, 1'b0);
            tx_start <= 1'b1;
            state_q  <= StSendLo;
          end
        end
        StSendLo: begin
          conv16to8ready <= 1'b1;
          state_q        <= StWaitLo;
        end
        StWaitLo: begin
          // On timeout the mux sees no ready&tx_done, so the same word is resent.
          if (tx_done || wd_expired) begin
            if (!tx_done) begin
              timeout_err <= 1'b1;
            end
            conv16to8ready <= 1'b0;
            settle_q       <= '0;
            state_q        <= StSettle;
          end
        end
        default: begin
          conv16to8ready <= 1'b0;
          settle_q       <= '0;
          state_q        <= StSettle;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_conv16to8.md
Name: uart_conv16to8

Overview:
- Downstream stage of the player-2 UART word multiplexer.
- Takes the registered 16-bit frame word {tag[3:0], payload[11:0]} and splits it into two bytes, high byte first.
- Drives the byte-wide UART transmitter with a start strobe per byte.
- Returns conv16to8ready so the multiplexer advances only on the tx_done that completes a full word.

Parameters:
- SETTLE_CYCLES, 2, cycles waited after a word-completing tx_done before data_in is sampled; covers mux sel + data register latency; legal 1..15.
- TIMEOUT_CYCLES, 1_000_000, max cycles in a WAIT state without tx_done before the byte is treated as done; 0 disables.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- data_in  in  16  word from the multiplexer, {tag, payload}
- tx_done  in  1  one-cycle pulse from the UART TX when a byte finishes
- tx_start  out  1  one-cycle strobe: UART TX loads tx_data
- tx_data  out  8  byte to transmit, registered, stable from the tx_start cycle until the next load
- conv16to8ready  out  1  high while the pending tx_done completes the current word
- timeout_err  out  1  sticky flag, set on any watchdog expiry, cleared only by rst

Behaviour:
- Reset (rst=1 at a clock edge): state=SETTLE, settle counter=0, watchdog=0, captured word=0, tx_start=0, tx_data=8'h00, conv16to8ready=0, timeout_err=0.
- States: SETTLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO. All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- SETTLE:
  - Counts SETTLE_CYCLES cycles.
  - On the edge ending the last of those cycles: captures data_in into word_q and goes to SEND_HI.
  - tx_done is ignored.
- SEND_HI (exactly 1 cycle): tx_start=1, tx_data=word_q[15:8]; next state WAIT_HI.
- WAIT_HI:
  - tx_done=1 → SEND_LO.
  - Watchdog reaching TIMEOUT_CYCLES-1 → SEND_LO, timeout_err<=1.
- SEND_LO (exactly 1 cycle): tx_start=1, tx_data=word_q[7:0]; next state WAIT_LO.
- WAIT_LO:
  - conv16to8ready=1 for the whole state.
  - tx_done=1 → SETTLE, counter=0.
  - Timeout → SETTLE, timeout_err<=1. The mux does not advance on a timeout, so the same word is resent.
- conv16to8ready is 0 in every state except WAIT_LO. The mux therefore advances exactly once per word, on the low-byte tx_done.
- Watchdog:
  - Cleared on entry to WAIT_HI and WAIT_LO; increments each cycle in those states.
  - Width = clog2(TIMEOUT_CYCLES)+1.
- tx_done arriving in SETTLE, SEND_HI or SEND_LO is dropped and not queued.
- tx_done coinciding with watchdog expiry: treated as a normal tx_done; timeout_err is not set.
- Latency: from a word-completing tx_done at cycle T, tx_start for the high byte is at cycle T+SETTLE_CYCLES+1.
- Words with tag 0 (mux idle/default) are sent unchanged; the receiver discards them.
- rst mid-operation: any in-flight byte is abandoned; behaviour restarts from SETTLE. tx_start is never asserted in the reset cycle.

Decomposition:
- Shared uart package holds:
  - state encoding localparams ST_SETTLE..ST_WAIT_LO
  - frame tag constants TAG_PL2_POSX=4'h1, TAG_PL2_POSY=4'h2, TAG_MATCH_CTRL=4'h3
  - FRAME_W=16, BYTE_W=8
- One natural sub-module: uart_tx_watchdog (counter + expiry compare, ports clk, rst, clear, run, expired), reusable by the receive-side deserializer.

Test Plan:
- Startup: release rst, data_in=16'h1ABC → tx_start at cycle 3 after reset release (SETTLE_CYCLES=2) with tx_data=8'h1A; conv16to8ready=0.
- Full word: data_in=16'h1ABC, tx_done 20 cycles after each start → second tx_start tx_data=8'hBC; conv16to8ready=1 only during WAIT_LO; exactly one ready&tx_done coincidence per word.
- Sequencing: change data_in to 16'h2055 exactly 2 cycles after the low-byte tx_done → next bytes 8'h20 then 8'h55; no byte of the old word resent.
- Spurious tx_done: pulse tx_done during SETTLE and SEND_HI → ignored; state still advances only on the tx_done in WAIT_HI.
- Timeout: TIMEOUT_CYCLES=50, withhold tx_done after high byte → at 50 cycles low byte sent, timeout_err=1 and stays 1; withhold again → same word resent starting 8'h1A.
- Reset mid-word: assert rst during WAIT_HI → tx_start=0, tx_data=8'h00, ready=0 next cycle; after release, the high byte of the current data_in is sent.
